// File: rtl/seven_segment_scan_ctrl_if.sv
// Bundle of the value handshake, scan controls and decoder/digit drive
// signals shared between the scan controller and whoever feeds it.
//
// Handshake: a value transfers on any rising clock edge where i_Value_DV and
// o_Value_Ready are both 1. i_Value_DV seen while o_Value_Ready is 0 is
// dropped, not held; the source must re-present the value once ready returns.
interface seven_segment_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    i_Enable;
  logic                    i_Lzb_En;
  logic [4*NUM_DIGITS-1:0] i_Value;
  logic                    i_Value_DV;
  logic                    o_Value_Ready;
  logic [3:0]              o_Binary_Num;
  logic [NUM_DIGITS-1:0]   o_Digit_En;
  logic                    o_Segment_Blank;
  logic                    o_Frame_Done;
  logic [1:0]              o_State;  // debug: 0 IDLE, 1 SETUP, 2 ON, 3 BLANK

  modport master (
    output i_Enable, i_Lzb_En, i_Value, i_Value_DV,
    input  o_Value_Ready, o_Binary_Num, o_Digit_En, o_Segment_Blank,
           o_Frame_Done, o_State
  );

  modport slave (
    input  i_Enable, i_Lzb_En, i_Value, i_Value_DV,
    output o_Value_Ready, o_Binary_Num, o_Digit_En, o_Segment_Blank,
           o_Frame_Done, o_State
  );
endinterface

// File: rtl/seven_segment_scan_ctrl.sv
// Multiplexed seven-segment scan controller. One shared registered decoder
// is fed a nibble per digit; digit enables are delayed one SETUP cycle so
// they line up with the decoder output. A pending/shown value pair keeps the
// display tear-free: new values only become visible at a frame boundary.
module seven_segment_scan_ctrl #(
  parameter int NUM_DIGITS       = 4,
  parameter int DWELL_CYCLES     = 25000,
  parameter int BLANK_CYCLES     = 250,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input logic                     i_Clk,
  input logic                     i_Rst,
  seven_segment_scan_ctrl_if.slave bus
);

  localparam int VW   = 4 * NUM_DIGITS;
  localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [NUM_DIGITS-1:0] EN_OFF =
    (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_ON    = 2'd2,
    S_BLANK = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [VW-1:0]   shown_q, shown_d;
  logic [VW-1:0]   pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  logic [3:0]      bin_q, bin_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic            blank_q, blank_d;
  logic            fd_q, fd_d;
  logic            commit;
  logic            advance;
  logic            lz_hide;

  // Nibble k of a packed display value.
  function automatic logic [3:0] nibble(input logic [VW-1:0] v, input logic [IW-1:0] k);
    logic [3:0] r;
    r = 4'd0;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (IW'(j) == k) r = v[4*j +: 4];
    return r;
  endfunction

  // Digit k is hidden when it and every more significant digit are zero.
  // Digit 0 always shows so a zero value still displays "0".
  function automatic logic lz_blanked(input logic [VW-1:0] v, input logic [IW-1:0] k,
                                      input logic lzb);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++)
      if ((j >= int'(k)) && (v[4*j +: 4] != 4'd0)) all_zero = 1'b0;
    return lzb && (k != '0) && all_zero;
  endfunction

  // Polarity-corrected one-hot enable for digit k.
  function automatic logic [NUM_DIGITS-1:0] digit_on(input logic [IW-1:0] k);
    logic [NUM_DIGITS-1:0] m;
    m = '0;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (IW'(j) == k) m[j] = 1'b1;
    return (DIGIT_ACTIVE_LOW != 0) ? ~m : m;
  endfunction

  // Next-state, handshake/commit and next registered outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    shown_d      = shown_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    bin_d        = bin_q;
    en_d         = EN_OFF;
    blank_d      = 1'b1;
    fd_d         = 1'b0;
    commit       = 1'b0;
    advance      = 1'b0;
    lz_hide      = 1'b0;

    if (bus.i_Value_DV && !pend_valid_q) begin
      pend_d       = bus.i_Value;
      pend_valid_d = 1'b1;
    end

    if (!bus.i_Enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      timer_d = '0;
      commit  = pend_valid_q && (state_q == S_IDLE);
    end else begin
      case (state_q)
        S_IDLE: begin
          commit  = pend_valid_q;
          state_d = S_SETUP;
          idx_d   = '0;
        end
        S_SETUP: begin
          state_d = S_ON;
          timer_d = TW'(DWELL_CYCLES - 1);
        end
        S_ON: begin
          if (timer_q == '0) begin
            if (BLANK_CYCLES > 0) begin
              state_d = S_BLANK;
              timer_d = TW'(BLANK_CYCLES - 1);
            end else begin
              advance = 1'b1;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_BLANK: begin
          if (timer_q == '0) advance = 1'b1;
          else               timer_d = timer_q - TW'(1);
        end
        default: state_d = S_IDLE;
      endcase

      if (advance) begin
        state_d = S_SETUP;
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          fd_d   = 1'b1;
          commit = pend_valid_q;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
    end

    if (commit) begin
      shown_d      = pend_q;
      pend_valid_d = 1'b0;
    end

    // Outputs describe the state being entered, so they are valid in that
    // state's own cycle.
    case (state_d)
      S_IDLE:  bin_d = 4'd0;
      S_SETUP: bin_d = nibble(shown_d, idx_d);
      S_ON: begin
        lz_hide = lz_blanked(shown_d, idx_d, bus.i_Lzb_En);
        en_d    = lz_hide ? EN_OFF : digit_on(idx_d);
        blank_d = lz_hide;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      timer_q      <= '0;
      shown_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      bin_q        <= 4'd0;
      en_q         <= EN_OFF;
      blank_q      <= 1'b1;
      fd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      shown_q      <= shown_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      bin_q        <= bin_d;
      en_q         <= en_d;
      blank_q      <= blank_d;
      fd_q         <= fd_d;
    end
  end

  assign bus.o_Value_Ready   = ~pend_valid_q;
  assign bus.o_Binary_Num    = bin_q;
  assign bus.o_Digit_En      = en_q;
  assign bus.o_Segment_Blank = blank_q;
  assign bus.o_Frame_Done    = fd_q;
  assign bus.o_State         = state_q;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Bench for seven_segment_scan_ctrl. dut_a: 4 digits, dwell 4, blank 2,
// active-high enables (period 7, frame 28). dut_b: blank 0, active-low
// enables (period 5, frame 20).
module tb_seven_segment_scan_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   cur_t;

  seven_segment_scan_ctrl_if #(.NUM_DIGITS(4)) bus_a();
  seven_segment_scan_ctrl_if #(.NUM_DIGITS(4)) bus_b();

  seven_segment_scan_ctrl #(
    .NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2), .DIGIT_ACTIVE_LOW(0)
  ) dut_a (.i_Clk(clk), .i_Rst(rst), .bus(bus_a));

  seven_segment_scan_ctrl #(
    .NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(0), .DIGIT_ACTIVE_LOW(1)
  ) dut_b (.i_Clk(clk), .i_Rst(rst), .bus(bus_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic        lzb;
    logic [3:0]  lit;   // hand-computed: which digits light up
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0h, expected %0h", name, cur_t, act, exp);
    end
  endtask

  // One cycle of dut_a against the 7-clock digit period.
  task automatic check_a(input int t, input logic [15:0] val, input logic [3:0] lit);
    int d;
    int p;
    logic on;
    logic [3:0] exp_en;
    d  = (t / 7) % 4;
    p  = t % 7;
    on = (p >= 1) && (p <= 4) && lit[d];
    exp_en = on ? (4'b0001 << d) : 4'b0000;
    cur_t = t;
    chk("a_digit_en", bus_a.o_Digit_En, exp_en);
    chk("a_seg_blank", bus_a.o_Segment_Blank, !on);
    chk("a_frame_done", bus_a.o_Frame_Done, (t > 0) && (t % 28 == 0));
    chk("a_state", bus_a.o_State, (p == 0) ? 1 : ((p <= 4) ? 2 : 3));
    if (p <= 4) chk("a_binary_num", bus_a.o_Binary_Num, val[4*d +: 4]);
  endtask

  // Reset, load a value while idle, then enable. Returns at the negedge just
  // before the first SETUP edge.
  task automatic start_a(input logic [15:0] val, input logic lzb);
    @(negedge clk);
    rst = 1'b1;
    bus_a.i_Enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_a.i_Value = val;
    bus_a.i_Value_DV = 1'b1;
    bus_a.i_Lzb_En = lzb;
    @(posedge clk);
    @(negedge clk);
    bus_a.i_Value_DV = 1'b0;
    chk("a_ready_after_load", bus_a.o_Value_Ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("a_ready_after_idle_commit", bus_a.o_Value_Ready, 1);
    bus_a.i_Enable = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cur_t = 0;
    rst = 1'b1;
    bus_a.i_Enable = 1'b0; bus_a.i_Lzb_En = 1'b0; bus_a.i_Value = '0; bus_a.i_Value_DV = 1'b0;
    bus_b.i_Enable = 1'b0; bus_b.i_Lzb_En = 1'b0; bus_b.i_Value = '0; bus_b.i_Value_DV = 1'b0;

    vecs[0] = '{16'h1234, 1'b0, 4'b1111};
    vecs[1] = '{16'h0070, 1'b1, 4'b0011};
    vecs[2] = '{16'h0000, 1'b1, 4'b0001};
    vecs[3] = '{16'h0070, 1'b0, 4'b1111};
    vecs[4] = '{16'h8001, 1'b1, 4'b1111};
    vecs[5] = '{16'h0500, 1'b1, 4'b0111};

    // reset state
    step();
    step();
    chk("rst_a_state", bus_a.o_State, 0);
    chk("rst_a_ready", bus_a.o_Value_Ready, 1);
    chk("rst_a_digit_en", bus_a.o_Digit_En, 4'h0);
    chk("rst_a_binary_num", bus_a.o_Binary_Num, 0);
    chk("rst_a_seg_blank", bus_a.o_Segment_Blank, 1);
    chk("rst_a_frame_done", bus_a.o_Frame_Done, 0);
    chk("rst_b_digit_en", bus_b.o_Digit_En, 4'hF);
    chk("rst_b_seg_blank", bus_b.o_Segment_Blank, 1);

    // table: one frame plus the boundary cycle per vector
    foreach (vecs[i]) begin
      start_a(vecs[i].value, vecs[i].lzb);
      for (int t = 0; t <= 29; t++) begin
        step();
        check_a(t, vecs[i].value, vecs[i].lit);
      end
    end

    // mid-frame load is deferred to the frame boundary; a second DV while
    // not ready is dropped
    start_a(16'h1234, 1'b0);
    for (int t = 0; t <= 90; t++) begin
      step();
      check_a(t, (t < 28) ? 16'h1234 : 16'hABCD, 4'hF);
      if (t == 10) begin
        bus_a.i_Value = 16'hABCD;
        bus_a.i_Value_DV = 1'b1;
      end
      if (t == 11) begin
        bus_a.i_Value_DV = 1'b0;
        chk("a_ready_low_mid_frame", bus_a.o_Value_Ready, 0);
      end
      if (t == 15) begin
        bus_a.i_Value = 16'h5555;
        bus_a.i_Value_DV = 1'b1;
      end
      if (t == 16) bus_a.i_Value_DV = 1'b0;
      if (t == 27) chk("a_ready_before_commit", bus_a.o_Value_Ready, 0);
      if (t == 28) chk("a_ready_after_commit", bus_a.o_Value_Ready, 1);
    end

    // enable drop during digit 2, restart from digit 0, then reset mid-scan
    start_a(16'h1234, 1'b0);
    for (int t = 0; t <= 16; t++) begin
      step();
      check_a(t, 16'h1234, 4'hF);
    end
    bus_a.i_Enable = 1'b0;
    step();
    chk("dis_digit_en", bus_a.o_Digit_En, 4'h0);
    chk("dis_seg_blank", bus_a.o_Segment_Blank, 1);
    chk("dis_state", bus_a.o_State, 0);
    step();
    chk("dis_hold_state", bus_a.o_State, 0);
    bus_a.i_Enable = 1'b1;
    for (int t = 0; t <= 16; t++) begin
      step();
      check_a(t, 16'h1234, 4'hF);
    end
    rst = 1'b1;
    step();
    chk("mrst_state", bus_a.o_State, 0);
    chk("mrst_digit_en", bus_a.o_Digit_En, 4'h0);
    chk("mrst_binary_num", bus_a.o_Binary_Num, 0);
    chk("mrst_seg_blank", bus_a.o_Segment_Blank, 1);
    chk("mrst_ready", bus_a.o_Value_Ready, 1);
    chk("mrst_frame_done", bus_a.o_Frame_Done, 0);
    rst = 1'b0;
    step();
    chk("mrst_restart_state", bus_a.o_State, 1);
    chk("mrst_restart_binary_num", bus_a.o_Binary_Num, 0);
    step();
    chk("mrst_restart_digit_en", bus_a.o_Digit_En, 4'b0001);
    bus_a.i_Enable = 1'b0;

    // no blank phase, active-low enables
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus_b.i_Value = 16'h1234;
    bus_b.i_Value_DV = 1'b1;
    step();
    bus_b.i_Value_DV = 1'b0;
    step();
    bus_b.i_Enable = 1'b1;
    for (int t = 0; t <= 41; t++) begin
      int d;
      int p;
      logic [3:0] exp_en;
      logic [3:0] act_on;
      logic [15:0] val;
      step();
      cur_t = t;
      val = 16'h1234;
      d = (t / 5) % 4;
      p = t % 5;
      exp_en = (p >= 1) ? ~(4'b0001 << d) : 4'b1111;
      act_on = ~bus_b.o_Digit_En;
      chk("b_digit_en", bus_b.o_Digit_En, exp_en);
      chk("b_onehot", ($countones(act_on) <= 1), 1);
      chk("b_seg_blank", bus_b.o_Segment_Blank, (p == 0));
      chk("b_frame_done", bus_b.o_Frame_Done, (t > 0) && (t % 20 == 0));
      chk("b_binary_num", bus_b.o_Binary_Num, val[4*d +: 4]);
    end
    bus_b.i_Enable = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
